clk_div_multi: RTL and testbench
================================

Name: clk_div_multi

Overview:
- Multi-channel programmable clock divider / clock-enable generator, successor to the fixed 50 MHz to 10 MHz divider.
- Each of CH channels has a runtime-loadable divide ratio and high time. Each channel emits a duty-controlled divided clock plus a one-cycle period-start tick.
- Sits beside the system clock root and feeds the PWM, commutation and sampling logic of the 3-phase motor path.
- New settings are applied glitch-free, only at a period boundary.

Parameters:
- CH, 3, number of independent channels
- DW, 8, width of the divide and high-time fields
- DEF_DIV, 5, divide ratio loaded into every channel at reset (must be 2 to 2^DW-1)
- DEF_HIGH, 2, high-time in input cycles loaded at reset

Ports:
- clk50mhz  in  1  system clock; all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- en  in  CH  per-channel run enable
- loadCh  in  CH  per-channel one-cycle load strobe for new settings
- divVal  in  CH*DW  divide ratio; channel i uses bits [i*DW +: DW]
- highVal  in  CH*DW  high time in input cycles; same packing
- clkOut  out  CH  divided clock, registered
- tick  out  CH  one-cycle pulse in the first cycle of each period, registered
- cfgErr  out  CH  sticky flag set when an illegal divVal is loaded

Behaviour:
- Per-channel state:
  - active divA/highA
  - shadow divS/highS plus pending flag
  - counter cnt (DW bits)
- Reset (rst high, asynchronous) puts each channel in this state:
  - divA=DEF_DIV, highA=DEF_HIGH
  - cnt=DEF_DIV-1
  - pending=0, clkOut=0, tick=0, cfgErr=0
- Load: on an edge with loadCh[i]=1:
  - divVal slice >= 2: divS/highS captured, pending=1, cfgErr[i] cleared.
  - divVal slice < 2: ignored, pending unchanged, cfgErr[i]=1 (sticky until the next legal load).
  - A load while pending=1 overwrites the shadow. Last load wins.
- Run (en[i]=1), each edge:
  - wrap = (cnt==divA-1)
  - cntN = wrap ? 0 : cnt+1
  - If wrap and pending: divA/highA take the shadow at this edge, pending=0.
  - Registered outputs: cnt<=cntN, tick<=(cntN==0), clkOut<=(cntN < highA_next).
  - highA_next is the value divA/highA hold after this edge, i.e. the new high time applies from the first cycle of the new period.
- Resulting waveform:
  - Period = divA cycles.
  - clkOut high for min(highA, divA) cycles starting at the tick cycle.
  - highA=0: clkOut constantly low.
  - highA>=divA: clkOut constantly high.
  - tick still pulses once per period in both constant cases.
- Simultaneous load and wrap on the same edge: the wrap applies the previously pending shadow (if any). The new load lands in the shadow and applies at the following wrap.
- Disabled (en[i]=0), each edge:
  - clkOut<=0, tick<=0
  - If pending: apply shadow immediately, pending=0.
  - cnt<=divA_next-1, so the first enabled edge wraps to cnt=0 with tick=1.
- Enable latency: en rises before edge k; at edge k tick=1 and clkOut=(highA>0).
- Disable latency: en falls before edge k; at edge k clkOut=0 and tick=0. No partial-period stretching beyond that cycle.
- Reset mid-period: all channels go to the reset state immediately; the shadow is lost.
- Channels are fully independent; there are no cross-channel phase guarantees except that channels enabled on the same edge with equal divA stay in phase.
- No combinational path from inputs to outputs.

Test Plan:
- Reset release, en=3'b111, defaults 5/2 → every channel: tick at cycles 1,6,11…; clkOut high 2 cycles, low 3 (10 MHz, 40% duty); all three channels identical.
- Ch0 running 5/2, loadCh=001 with divVal=8, highVal=4 at mid-period → current period completes at 5 cycles; next period 8 cycles, clkOut high exactly 4; tick spacing 5 then 8.
- loadCh=010 with divVal=1 → cfgErr[1]=1, ch1 keeps 5/2. Then load divVal=4, highVal=2 → cfgErr[1]=0, 50% duty from the next wrap.
- highVal=0 then highVal=9 with divVal=6 → clkOut stuck 0, then stuck 1; tick every 6 cycles in both cases.
- en[2] dropped mid-period, load 3/1 while disabled, en[2] re-raised → clkOut=0 and tick=0 while disabled; first enabled edge tick=1, clkOut=1; period 3.
- Load coincident with wrap while an earlier load is pending, followed by rst asserted mid-period → pending shadow applied at that wrap, new one at the next wrap; after rst: cnt=4, outputs 0, cfgErr=0, defaults restored.

Source files
------------

// File: rtl/clk_div_multi.sv
// Multi-channel programmable clock divider / clock-enable generator.
// Each channel: loadable divide ratio and high time, glitch-free update at wrap.
module clk_div_multi #(
    parameter int CH       = 3,
    parameter int DW       = 8,
    parameter int DEF_DIV  = 5,
    parameter int DEF_HIGH = 2
) (
    input  logic             clk50mhz,
    input  logic             rst,
    input  logic [CH-1:0]    en,
    input  logic [CH-1:0]    loadCh,
    input  logic [CH*DW-1:0] divVal,
    input  logic [CH*DW-1:0] highVal,
    output logic [CH-1:0]    clkOut,
    output logic [CH-1:0]    tick,
    output logic [CH-1:0]    cfgErr
);

    logic [DW-1:0] div_a_q  [CH];
    logic [DW-1:0] div_a_d  [CH];
    logic [DW-1:0] high_a_q [CH];
    logic [DW-1:0] high_a_d [CH];
    logic [DW-1:0] div_s_q  [CH];
    logic [DW-1:0] div_s_d  [CH];
    logic [DW-1:0] high_s_q [CH];
    logic [DW-1:0] high_s_d [CH];
    logic [DW-1:0] cnt_q    [CH];
    logic [DW-1:0] cnt_d    [CH];
    logic [CH-1:0] pend_q, pend_d;
    logic [CH-1:0] clk_q, clk_d;
    logic [CH-1:0] tick_q, tick_d;
    logic [CH-1:0] err_q, err_d;

    // Per-channel next state: counter, shadow capture, boundary apply, outputs
    always_comb begin
        logic [DW-1:0] div_in;
        logic [DW-1:0] high_in;
        logic [DW-1:0] div_nx;
        logic [DW-1:0] high_nx;
        logic [DW-1:0] cnt_nx;
        logic          wrap;
        logic          legal;
        logic          apply;
        div_in  = '0;
        high_in = '0;
        div_nx  = '0;
        high_nx = '0;
        cnt_nx  = '0;
        wrap    = 1'b0;
        legal   = 1'b0;
        apply   = 1'b0;
        pend_d  = pend_q;
        clk_d   = '0;
        tick_d  = '0;
        err_d   = err_q;
        for (int i = 0; i < CH; i++) begin
            div_in  = divVal[i*DW +: DW];
            high_in = highVal[i*DW +: DW];
            legal   = loadCh[i] && (div_in >= DW'(2));
            wrap    = (cnt_q[i] == div_a_q[i] - DW'(1));
            // A pending shadow lands at a wrap, or at once while stopped.
            apply   = pend_q[i] && (!en[i] || wrap);
            div_nx  = apply ? div_s_q[i]  : div_a_q[i];
            high_nx = apply ? high_s_q[i] : high_a_q[i];
            if (en[i]) begin
                cnt_nx = wrap ? '0 : cnt_q[i] + DW'(1);
            end else begin
                // Park at the last count so the first enabled edge wraps.
                cnt_nx = div_nx - DW'(1);
            end
            div_a_d[i]  = div_nx;
            high_a_d[i] = high_nx;
            cnt_d[i]    = cnt_nx;
            // The shadow captured on this edge waits for the next boundary.
            div_s_d[i]  = legal ? div_in  : div_s_q[i];
            high_s_d[i] = legal ? high_in : high_s_q[i];
            pend_d[i]   = legal ? 1'b1 : (apply ? 1'b0 : pend_q[i]);
            err_d[i]    = loadCh[i] ? !legal : err_q[i];
            clk_d[i]    = en[i] && (cnt_nx < high_nx);
            tick_d[i]   = en[i] && (cnt_nx == '0);
        end
    end

    // State registers, asynchronous reset to the default ratio
    always_ff @(posedge clk50mhz or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < CH; i++) begin
                div_a_q[i]  <= DW'(DEF_DIV);
                high_a_q[i] <= DW'(DEF_HIGH);
                div_s_q[i]  <= DW'(DEF_DIV);
                high_s_q[i] <= DW'(DEF_HIGH);
                cnt_q[i]    <= DW'(DEF_DIV - 1);
            end
            pend_q <= '0;
            clk_q  <= '0;
            tick_q <= '0;
            err_q  <= '0;
        end else begin
            for (int i = 0; i < CH; i++) begin
                div_a_q[i]  <= div_a_d[i];
                high_a_q[i] <= high_a_d[i];
                div_s_q[i]  <= div_s_d[i];
                high_s_q[i] <= high_s_d[i];
                cnt_q[i]    <= cnt_d[i];
            end
            pend_q <= pend_d;
            clk_q  <= clk_d;
            tick_q <= tick_d;
            err_q  <= err_d;
        end
    end

    assign clkOut = clk_q;
    assign tick   = tick_q;
    assign cfgErr = err_q;

endmodule

// File: tb/tb_clk_div_multi.sv
// Testbench for clk_div_multi: vector table plus expected-waveform queue.
// Expected entries are pushed with the stimulus and popped after each edge.
module tb_clk_div_multi;

    localparam int CH = 3;
    localparam int DW = 8;

    logic             clk50mhz;
    logic             rst;
    logic [CH-1:0]    en;
    logic [CH-1:0]    loadCh;
    logic [CH*DW-1:0] divVal;
    logic [CH*DW-1:0] highVal;
    logic [CH-1:0]    clkOut;
    logic [CH-1:0]    tick;
    logic [CH-1:0]    cfgErr;

    clk_div_multi #(
        .CH(CH), .DW(DW), .DEF_DIV(5), .DEF_HIGH(2)
    ) dut (
        .clk50mhz(clk50mhz),
        .rst(rst),
        .en(en),
        .loadCh(loadCh),
        .divVal(divVal),
        .highVal(highVal),
        .clkOut(clkOut),
        .tick(tick),
        .cfgErr(cfgErr)
    );

    typedef struct {
        logic [CH-1:0] msk;
        logic [CH-1:0] clk;
        logic [CH-1:0] tck;
        logic [CH-1:0] err;
    } exp_t;

    typedef struct {
        logic [CH-1:0] en;
        logic [CH-1:0] clk;
        logic [CH-1:0] tck;
    } vec_t;

    exp_t  sb[$];
    vec_t  tbl[11];
    int    n_run;
    int    n_fail;
    string tname;

    initial begin
        clk50mhz = 1'b0;
        forever #10 clk50mhz = ~clk50mhz;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_run++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s/%s: got 0x%0h expected 0x%0h", tname, nm, act, req);
        end
    endtask

    task automatic push_per(input int ch, input int dv, input int hv, input bit er);
        exp_t e;
        for (int k = 0; k < dv; k++) begin
            e.msk = '0;
            e.clk = '0;
            e.tck = '0;
            e.err = '0;
            e.msk[ch] = 1'b1;
            e.clk[ch] = (k < hv);
            e.tck[ch] = (k == 0);
            e.err[ch] = er;
            sb.push_back(e);
        end
    endtask

    task automatic push_one(input int ch, input bit c, input bit t, input bit er);
        exp_t e;
        e.msk = '0;
        e.clk = '0;
        e.tck = '0;
        e.err = '0;
        e.msk[ch] = 1'b1;
        e.clk[ch] = c;
        e.tck[ch] = t;
        e.err[ch] = er;
        sb.push_back(e);
    endtask

    task automatic cyc();
        exp_t e;
        logic [3*CH-1:0] act;
        logic [3*CH-1:0] req;
        @(posedge clk50mhz);
        #1;
        loadCh = '0;
        if (sb.size() != 0) begin
            e   = sb.pop_front();
            act = {clkOut & e.msk, tick & e.msk, cfgErr & e.msk};
            req = {e.clk & e.msk, e.tck & e.msk, e.err & e.msk};
            n_run++;
            if (act !== req) begin
                n_fail++;
                $display("FAIL %s/wave: {clk,tick,err} got %b expected %b",
                         tname, act, req);
            end
        end
    endtask

    task automatic cycles(input int n);
        for (int k = 0; k < n; k++) cyc();
    endtask

    task automatic set_cfg(input int ch, input int dv, input int hv);
        divVal[ch*DW +: DW]  = DW'(dv);
        highVal[ch*DW +: DW] = DW'(hv);
        loadCh[ch]           = 1'b1;
    endtask

    task automatic do_reset();
        rst    = 1'b1;
        loadCh = '0;
        #1;
        chk("rst_async", {29'd0, clkOut | tick | cfgErr}, 32'd0);
        @(posedge clk50mhz);
        #1;
        chk("rst_hold", {29'd0, clkOut | tick | cfgErr}, 32'd0);
        rst = 1'b0;
    endtask

    initial begin
        n_run   = 0;
        n_fail  = 0;
        rst     = 1'b1;
        en      = '0;
        loadCh  = '0;
        divVal  = '0;
        highVal = '0;

        tbl[0]  = '{3'b000, 3'b000, 3'b000};
        tbl[1]  = '{3'b111, 3'b111, 3'b111};
        tbl[2]  = '{3'b111, 3'b111, 3'b000};
        tbl[3]  = '{3'b111, 3'b000, 3'b000};
        tbl[4]  = '{3'b111, 3'b000, 3'b000};
        tbl[5]  = '{3'b111, 3'b000, 3'b000};
        tbl[6]  = '{3'b111, 3'b111, 3'b111};
        tbl[7]  = '{3'b111, 3'b111, 3'b000};
        tbl[8]  = '{3'b111, 3'b000, 3'b000};
        tbl[9]  = '{3'b111, 3'b000, 3'b000};
        tbl[10] = '{3'b111, 3'b000, 3'b000};

        tname = "defaults";
        @(posedge clk50mhz);
        #1;
        do_reset();
        for (int i = 0; i < 11; i++) begin
            exp_t e;
            en    = tbl[i].en;
            e.msk = '1;
            e.clk = tbl[i].clk;
            e.tck = tbl[i].tck;
            e.err = '0;
            sb.push_back(e);
            cyc();
        end

        tname = "reload";
        en = '0;
        do_reset();
        en = 3'b001;
        push_per(0, 5, 2, 0);
        cycles(2);
        set_cfg(0, 8, 4);
        cycles(3);
        push_per(0, 8, 4, 0);
        push_per(0, 8, 4, 0);
        cycles(16);

        tname = "cfgerr";
        en = '0;
        do_reset();
        en = 3'b010;
        push_per(1, 5, 2, 1);
        set_cfg(1, 1, 3);
        cycles(5);
        push_per(1, 5, 2, 1);
        push_per(1, 5, 2, 1);
        cycles(10);
        push_per(1, 5, 2, 0);
        set_cfg(1, 4, 2);
        cycles(5);
        push_per(1, 4, 2, 0);
        push_per(1, 4, 2, 0);
        cycles(8);

        tname = "high_edge";
        en = '0;
        do_reset();
        en = 3'b100;
        push_per(2, 5, 2, 0);
        set_cfg(2, 6, 0);
        cycles(5);
        push_per(2, 6, 0, 0);
        cycles(6);
        push_per(2, 6, 0, 0);
        set_cfg(2, 6, 9);
        cycles(6);
        push_per(2, 6, 9, 0);
        push_per(2, 6, 9, 0);
        cycles(12);

        tname = "disable";
        en = '0;
        do_reset();
        en = 3'b100;
        push_per(2, 5, 2, 0);
        cycles(5);
        push_one(2, 1, 1, 0);
        push_one(2, 1, 0, 0);
        cycles(2);
        en = 3'b000;
        push_one(2, 0, 0, 0);
        push_one(2, 0, 0, 0);
        push_one(2, 0, 0, 0);
        cyc();
        set_cfg(2, 3, 1);
        cycles(2);
        en = 3'b100;
        push_per(2, 3, 1, 0);
        push_per(2, 3, 1, 0);
        cycles(6);

        tname = "pend_wrap";
        en = '0;
        do_reset();
        en = 3'b001;
        push_per(0, 5, 2, 0);
        cyc();
        set_cfg(0, 6, 3);
        cycles(4);
        push_per(0, 6, 3, 0);
        set_cfg(0, 4, 1);
        set_cfg(1, 0, 0);
        cycles(6);
        chk("err_sticky", {31'd0, cfgErr[1]}, 32'd1);
        push_one(0, 1, 1, 0);
        push_one(0, 0, 0, 0);
        cycles(2);
        do_reset();
        push_per(0, 5, 2, 0);
        push_per(0, 5, 2, 0);
        cycles(10);

        tname = "end";
        chk("sb_empty", sb.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
